uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter for the UART subsystem. It is the next-generation replacement for the fixed-format transmitter. It buffers outgoing characters in an internal FIFO and serialises them LSB first on `tx`. Data width, FIFO depth and oversampling ratio are parameters; parity mode and stop-bit count are selectable at run time. It is paced by the oversampling tick from the shared baud generator.

## Interface
- `DATA_W`, default 8: character width in bits; legal range 5..9.
- `DEPTH`, default 4: FIFO depth in characters; must be a power of two, at least 2.
- `OVERSAMPLE`, default 16: number of `b_tick` pulses per bit period; at least 2.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `b_tick`  in  1  one-`clk` oversampling pulse from the baud generator.
- `wr_en`  in  1  write strobe; pushes `wr_data` into the FIFO.
- `wr_data`  in  DATA_W  character to send.
- `parity_sel`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
- `stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `tx_done`  out  1  one-`clk` pulse when the last stop bit completes.
- `full`  out  1  FIFO holds DEPTH entries.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `overflow`  out  1  one-`clk` pulse when a write is dropped.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `tx_done`=0, `full`=0, `level`=0, `overflow`=0. The FIFO is emptied and the FSM is in IDLE.
- **FIFO write:** a write is accepted when `wr_en`=1 and the registered `full`=0. If `wr_en`=1 and `full`=1, the data is dropped, `overflow` pulses, and `level` is unchanged.
- **Simultaneous write and pop while not full:** `level` is unchanged and the characters stay in order.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** if `level`>0, pop the head entry this cycle. Latch the data, `parity_sel` and `stop2` into frame registers, then go to START. Config changes mid-frame have no effect on the current frame.
- **Bit timing:** a tick counter runs from 0 to OVERSAMPLE-1 and advances only on `b_tick`. A bit ends on the `b_tick` where the counter equals OVERSAMPLE-1; the counter then returns to 0.
- **START:** `tx`=0 for one bit period, then go to DATA.
- **DATA:** send DATA_W bits LSB first, using a bit index from 0 to DATA_W-1. After the last bit, go to PARITY if the parity mode is not 00, otherwise go to STOP.
- **PARITY bit value:**
  - even: XOR of the data bits;
  - odd: inverse of that XOR;
  - mark: 1.
- **STOP:** `tx`=1 for one bit period, or two if `stop2` was latched as 1. At the end, pulse `tx_done` and return to IDLE.
- **Frame length:** OVERSAMPLE × (1 + DATA_W + P + S) `b_tick`s, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- **Reset mid-frame:** all outputs take their reset values immediately (asynchronously). The partial frame and all FIFO contents are discarded.

## Timing
- `tx` is a registered output.
- Idle to start bit: `wr_en` into an empty FIFO at cycle n means `level`=1 at n+1, pop at n+1, and `tx`=0 at n+2.
- `busy` rises in the same cycle `tx` first goes low. It falls in the cycle after `tx_done`.
- Back-to-back frames: when the FIFO is non-empty at the end of STOP, the next start bit begins 2 `clk` after the `tx_done` cycle. `tx` stays high during that gap.
- `full` and `level` update in the cycle after the write or pop.
- `overflow` pulses in the cycle after the rejected `wr_en`.

## Test plan
All scenarios use DATA_W=8, DEPTH=4, OVERSAMPLE=16, `b_tick` tied to 1 (one bit = 16 `clk`) unless a scenario says otherwise.
- **Basic frame:** write 0xA5, `parity_sel`=00, `stop2`=0 → `tx` reads 0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 clk. `tx_done` pulses after 160 clk. `busy` is high for exactly 160 clk.
- **Parity:** write 0x07 with `parity_sel`=01 → parity bit 1 and frame 176 clk. Repeat with 10 → parity bit 0. Repeat with 11 → parity bit 1.
- **Two stop bits:** write 0x00, `stop2`=1, no parity → 8 low data bits, then `tx` high for 32 clk before `tx_done`; frame 176 clk.
- **Overflow:** during an active frame, write 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles → `full`=1, `level`=4, `overflow` pulses once for 0x55. The four accepted characters are then sent in order with 2-clk gaps; 0x55 is never sent.
- **Reset mid-frame:** drop `resetn` during data bit 3 → `tx`=1, `busy`=0, `level`=0 immediately. After release, `tx` stays high with no new write.
- **Tick gating:** `b_tick` pulses every 4 clk, write 0x3C, no parity → each bit lasts 64 clk and the frame lasts 640 clk.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Characters written through wr_en/wr_data are queued in a DEPTH-entry FIFO.
// They are sent LSB first on tx as: start bit, DATA_W data bits, an optional
// parity bit, then one or two stop bits. Each bit lasts OVERSAMPLE b_tick pulses.
//
// Ports:
//   clk, resetn          system clock; asynchronous active-low reset
//   b_tick               one-clk oversampling pulse from the baud generator
//   wr_en, wr_data       FIFO write strobe and character
//   parity_sel           00 none, 01 even, 10 odd, 11 mark (sampled at frame start)
//   stop2                0 = one stop bit, 1 = two (sampled at frame start)
//   tx                   registered serial output, idles high
//   busy                 frame in progress
//   tx_done              one-clk pulse on the b_tick that ends the last stop bit
//   full, level          FIFO status (registered occupancy)
//   overflow             one-clk pulse, the cycle after a write is dropped
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       b_tick,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [1:0]                 parity_sel,
  input  logic                       stop2,
  output logic                       tx,
  output logic                       busy,
  output logic                       tx_done,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW  = $clog2(DATA_W);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and status
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              ovf_q;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Transmit FSM state and frame registers
  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign full = (level_q == LvlW'(DEPTH));
  assign push = wr_en & ~full;
  // The FSM drains the FIFO only from IDLE, so a pop never overlaps a frame.
  assign pop  = (state_q == StIdle) && (level_q != '0);
  assign head = mem_q[rptr_q];

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_d;
      ovf_q   <= wr_en & full;
    end
  end

  // Oversampling counter: advances only on b_tick, held at zero in IDLE so every
  // frame starts with a full-length start bit counted from its first tick.
  assign bit_end = b_tick && (tick_q == TickW'(OVERSAMPLE - 1));

  always_comb begin
    tick_d = tick_q;
    if (state_q == StIdle) begin
      tick_d = '0;
    end else if (b_tick) begin
      tick_d = bit_end ? '0 : tick_q + TickW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    tx_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (pop) begin
          // Parity is taken from the whole character now, since data_q is
          // consumed by shifting during DATA.
          data_d   = head;
          par_en_d = (parity_sel != 2'b00);
          unique case (parity_sel)
            2'b01:   par_bit_d = ^head;
            2'b10:   par_bit_d = ~^head;
            default: par_bit_d = 1'b1;
          endcase
          stop2_d    = stop2;
          idx_d      = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d    = data_q[0];
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxW'(DATA_W - 1)) begin
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            tx_d   = data_q[1];
            data_d = data_q >> 1;
            idx_d  = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            tx_done = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle);
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with default parameters (8 data bits,
// 4-deep FIFO, 16 ticks per bit). Inputs change and outputs are sampled on the
// falling clock edge. Expected frames are written LSB first as
// {stop bit(s), [parity], data, start}.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       b_tick;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [1:0] parity_sel;
  logic       stop2;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic       full;
  logic [2:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // b_tick is either tied high or pulsed once every 4 clocks.
  logic       tick_div;
  logic [1:0] div = 2'd0;
  always @(posedge clk) div <= div + 2'd1;
  assign b_tick = tick_div ? (div == 2'd0) : 1'b1;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk        (clk),
    .resetn     (resetn),
    .b_tick     (b_tick),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .parity_sel (parity_sel),
    .stop2      (stop2),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .full       (full),
    .level      (level),
    .overflow   (overflow)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the write is taken on the next rising edge.
  task automatic send(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Called on the first cycle of a frame (tx should just have gone low).
  // Returns on the frame's last cycle, where tx_done must be high.
  task automatic check_frame(input logic [15:0] bits, input int nbits, input int bitlen,
                             input string tag);
    int   done_at;
    int   busy_cnt;
    logic exp_bit;
    logic obs_bit;
    done_at  = -1;
    busy_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      exp_bit = bits[b];
      obs_bit = exp_bit;
      for (int c = 0; c < bitlen; c++) begin
        if (tx !== exp_bit) obs_bit = tx;
        if (busy === 1'b1) busy_cnt++;
        if (tx_done === 1'b1 && done_at < 0) done_at = b * bitlen + c;
        if (!(b == nbits - 1 && c == bitlen - 1)) @(negedge clk);
      end
      chk(32'(obs_bit), 32'(exp_bit), $sformatf("%s bit%0d", tag, b));
    end
    chk(done_at, nbits * bitlen - 1, {tag, " tx_done cycle"});
    chk(busy_cnt, nbits * bitlen, {tag, " busy cycles"});
  endtask

  logic [15:0] ovf_frames [4];
  int          exp_lvl  [5];
  logic        exp_full [5];
  logic        exp_ovf  [5];
  int          n;
  int          lows;

  initial begin
    ovf_frames = '{16'b1_00010001_0, 16'b1_00100010_0, 16'b1_00110011_0, 16'b1_01000100_0};
    exp_lvl    = '{1, 2, 3, 4, 4};
    exp_full   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_ovf    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    resetn     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    parity_sel = 2'b00;
    stop2      = 1'b0;
    tick_div   = 1'b0;
    repeat (3) @(negedge clk);
    chk(tx, 1, "reset tx");
    chk(busy, 0, "reset busy");
    chk(tx_done, 0, "reset tx_done");
    chk(full, 0, "reset full");
    chk(level, 0, "reset level");
    chk(overflow, 0, "reset overflow");
    resetn = 1'b1;
    @(negedge clk);

    // Basic frame 0xA5, no parity, one stop bit
    send(8'hA5);
    chk(level, 1, "basic level after write");
    chk(tx, 1, "basic tx before start");
    chk(busy, 0, "basic busy before start");
    @(negedge clk);
    chk(level, 0, "basic level after pop");
    check_frame(16'b1_10100101_0, 10, 16, "basic");
    @(negedge clk);
    chk(busy, 0, "basic busy after");
    chk(tx, 1, "basic tx after");

    // Parity: even, odd (config changed mid-frame), mark
    parity_sel = 2'b01;
    send(8'h07);
    @(negedge clk);
    check_frame(16'b1_1_00000111_0, 11, 16, "even");
    @(negedge clk);
    parity_sel = 2'b10;
    send(8'h07);
    @(negedge clk);
    parity_sel = 2'b00;
    stop2      = 1'b1;
    check_frame(16'b1_0_00000111_0, 11, 16, "odd");
    @(negedge clk);
    stop2      = 1'b0;
    parity_sel = 2'b11;
    send(8'h07);
    @(negedge clk);
    check_frame(16'b1_1_00000111_0, 11, 16, "mark");
    @(negedge clk);

    // Two stop bits
    parity_sel = 2'b00;
    stop2      = 1'b1;
    send(8'h00);
    @(negedge clk);
    check_frame(16'b11_00000000_0, 11, 16, "stop2");
    @(negedge clk);
    stop2 = 1'b0;

    // Overflow while a frame is running
    send(8'h99);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h11 * (i + 1));
      wr_en   = 1'b1;
      @(negedge clk);
      chk(level, exp_lvl[i], $sformatf("ovf level w%0d", i));
      chk(full, exp_full[i], $sformatf("ovf full w%0d", i));
      chk(overflow, exp_ovf[i], $sformatf("ovf pulse w%0d", i));
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk(overflow, 0, "ovf pulse end");
    chk(level, 4, "ovf level held");
    n = 0;
    while (tx_done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tx_done, 1, "ovf first frame done");
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk(tx, 1, $sformatf("gap%0d tx", j));
      chk(busy, 0, $sformatf("gap%0d busy", j));
      chk(level, 4 - j, $sformatf("gap%0d level", j));
      @(negedge clk);
      check_frame(ovf_frames[j], 10, 16, $sformatf("queued%0d", j));
    end
    @(negedge clk);
    chk(busy, 0, "ovf drained busy");
    chk(level, 0, "ovf drained level");
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk(lows, 0, "dropped char never sent");

    // Reset during data bit 3
    send(8'h52);
    @(negedge clk);
    wr_data = 8'h66;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    chk(level, 1, "rst queued level");
    repeat (69) @(negedge clk);
    chk(tx, 0, "rst data bit3 before reset");
    chk(busy, 1, "rst busy before reset");
    resetn = 1'b0;
    #1;
    chk(tx, 1, "rst async tx");
    chk(busy, 0, "rst async busy");
    chk(level, 0, "rst async level");
    @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk(lows, 0, "rst line stays idle");

    // Tick gating: b_tick every 4 clocks, aligned so the pop cycle carries a tick
    tick_div = 1'b1;
    n = 0;
    while (div != 2'd3 && n < 8) begin
      @(negedge clk);
      n++;
    end
    send(8'h3C);
    @(negedge clk);
    check_frame(16'b1_00111100_0, 10, 64, "tick");
    @(negedge clk);
    chk(busy, 0, "tick busy after");
    chk(tx, 1, "tick tx after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
